ll_step_sequencer: RTL and testbench
====================================

// Module: ll_step_sequencer
// PURPOSE
//   Sequences the lunar-lander physics datapath (BCD ALU + state memory).
//   Divides hz100 into physics steps, runs each step as EVAL -> COMMIT,
//   and drives the one-cycle memory write enable. Owns the thrust register
//   fed from keypad digits, landing/crash detection, pause and step counting.
//   Sits between keysync/keypad logic and ll_memory/ll_alu in the top level.
// PARAMETERS
//   TICK_DIV   25        hz100 cycles spent in RUN per physics step (>=2)
//   CRASH_VEL  16'h9970  BCD ten's-complement crash threshold (-30)
//   THRUST     16'h0005  thrust value after reset
// PORTS
//   hz100      in   1   system clock
//   reset_n    in   1   asynchronous, active-low reset
//   start      in   1   level; IDLE -> RUN when sampled high
//   pause      in   1   level; holds the step timer while high
//   key_valid  in   1   one-cycle strobe, key_digit valid
//   key_digit  in   4   binary keypad digit; values >9 ignored
//   fuel       in   16  current fuel (BCD)
//   vel        in   16  current velocity (BCD ten's complement)
//   alt_c      in   16  raw ALU alt+vel sum (BCD ten's complement)
//   wen        out  1   memory write enable, high only in COMMIT
//   thrust     out  16  {12'h000, thr_reg}, to memory thrust_n
//   land       out  1   sticky: landed safely
//   crash      out  1   sticky: crashed
//   busy       out  1   high in RUN/PAUSED/EVAL/COMMIT
//   step_cnt   out  8   binary count of COMMITs, saturates at 255
//   state      out  3   IDLE=0 RUN=1 EVAL=2 COMMIT=3 PAUSED=4 LANDED=5 CRASHED=6
// BEHAVIOUR
//   Reset (async, reset_n low): state IDLE, wen 0, thr_reg THRUST[3:0],
//     hold register empty, land 0, crash 0, step_cnt 0, busy 0, timer 0.
//   All outputs registered or decoded from registered state; no comb paths from inputs.
//   IDLE: start high -> RUN, timer 0. Otherwise stay.
//   RUN: pause high -> PAUSED (pause wins over terminal count, timer holds).
//     Else timer increments; at timer==TICK_DIV-1 -> EVAL, timer cleared.
//     RUN occupies exactly TICK_DIV cycles; step period TICK_DIV+2 cycles.
//   PAUSED: timer frozen; pause low -> RUN resuming at held timer value.
//   EVAL (1 cycle): ground = alt_c[15] | (alt_c==16'h0000).
//     Registers gnd flag and crash flag = ground & (vel < CRASH_VEL), 16-bit
//     unsigned compare (valid: both operands negative ten's complement).
//   COMMIT (1 cycle): wen=1, step_cnt+1 (sat 255). If fuel==16'h0000,
//     thr_reg cleared to 0 at this edge. Next: crash flag -> CRASHED (crash=1);
//     else gnd -> LANDED (land=1); else RUN. Ground step still commits once
//     (ALU clamps alt to 0).
//   LANDED/CRASHED: terminal; wen 0; start, pause, keys ignored; exit only by reset.
//   land and crash never both 1.
//   Keys: key_valid & key_digit<=9 in IDLE/RUN/PAUSED -> thr_reg=key_digit next edge.
//     In EVAL/COMMIT: digit latched into 1-entry hold register (later key
//     overwrites earlier); applied on first cycle after return to RUN, then emptied.
//     Hold register discarded on entry to LANDED/CRASHED.
//     Fuel-empty clear in COMMIT takes priority over a key in the same cycle.
//   Reset mid-step (any state): immediate return to reset values; no wen glitch.
// TESTING
//   TICK_DIV=4, reset, start=1 one cycle -> RUN; wen high exactly 1 cycle every
//     6 cycles, first at 6th cycle after RUN entry; step_cnt 1,2,3...
//   pause high for 10 cycles mid-RUN (timer=2) -> state 4, no wen; release ->
//     wen 2+1+... exactly 3 cycles later (remaining RUN 2 + EVAL 1), then COMMIT.
//   alt_c=16'h9990, vel=16'h9960 at EVAL -> one wen pulse, then state 6, crash=1,
//     land=0; further start/keys produce no wen.
//   alt_c=16'h0000, vel=16'h9970 (boundary) -> LANDED, land=1; vel=16'h9969 -> CRASHED.
//   key 7 during EVAL -> thrust stays old through COMMIT, becomes 16'h0007 on
//     2nd cycle back in RUN; key 12 (>9) -> thrust unchanged.
//   fuel=16'h0000 at COMMIT with key 3 same cycle -> thrust 16'h0000; reset_n low in
//     EVAL -> state 0, thrust 16'h0005, step_cnt 0, wen 0.

Source files
------------

// File: rtl/ll_step_sequencer_if.sv
// Handshake/data bundle between the lander top level and the step sequencer.
// The master side drives the keypad, control levels and memory/ALU values;
// the slave side (the sequencer) returns write enable, thrust and status.
interface ll_step_sequencer_if;
   logic        start;
   logic        pause;
   logic        key_valid;
   logic [3:0]  key_digit;
   logic [15:0] fuel;
   logic [15:0] vel;
   logic [15:0] alt_c;
   logic        wen;
   logic [15:0] thrust;
   logic        land;
   logic        crash;
   logic        busy;
   logic [7:0]  step_cnt;
   logic [2:0]  state;

   modport master (
      output start, pause, key_valid, key_digit, fuel, vel, alt_c,
      input  wen, thrust, land, crash, busy, step_cnt, state
   );

   modport slave (
      input  start, pause, key_valid, key_digit, fuel, vel, alt_c,
      output wen, thrust, land, crash, busy, step_cnt, state
   );
endinterface

// File: rtl/ll_step_sequencer.sv
// Lunar-lander physics step sequencer. Divides hz100 into physics steps,
// runs each step as RUN -> EVAL -> COMMIT, pulses the memory write enable
// in COMMIT, and owns the keypad thrust register, landing/crash detection,
// pause handling and the saturating step counter. Every output comes from a
// register so nothing combinational leaks from the inputs.
module ll_step_sequencer #(
   parameter int          TICK_DIV  = 25,
   parameter logic [15:0] CRASH_VEL = 16'h9970,
   parameter logic [15:0] THRUST    = 16'h0005
) (
   input logic            hz100,
   input logic            reset_n,
   ll_step_sequencer_if.slave bus
);

   localparam int          TW   = $clog2(TICK_DIV);
   localparam logic [TW-1:0] LAST = TW'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_EVAL    = 3'd2,
      S_COMMIT  = 3'd3,
      S_PAUSED  = 3'd4,
      S_LANDED  = 3'd5,
      S_CRASHED = 3'd6
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          wen_q;
   logic          busy_q;
   logic          land_q;
   logic          crash_q;
   logic [7:0]    step_cnt_q;
   logic          gnd_q;
   logic          crashf_q;
   logic [3:0]    thr_q, thr_d;
   logic [3:0]    hold_q, hold_d;
   logic          hold_vld_q, hold_vld_d;

   logic          key_ok;
   logic          ground;
   logic          crash_now;
   logic          fuel_empty;
   logic          to_terminal;

   // Input qualification: valid digits, ground contact and crash speed.
   always_comb begin
      key_ok     = bus.key_valid && (bus.key_digit <= 4'd9);
      ground     = bus.alt_c[15] || (bus.alt_c == 16'h0000);
      // Both operands are negative ten's-complement BCD here, so a plain
      // unsigned compare orders them by descent speed.
      crash_now  = ground && (bus.vel < CRASH_VEL);
      fuel_empty = (bus.fuel == 16'h0000);
   end

   // Next-state and step-timer logic of the step FSM.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_RUN;
               timer_d = '0;
            end
         end
         S_RUN: begin
            // Pause beats the terminal count; the timer simply holds.
            if (bus.pause) begin
               state_d = S_PAUSED;
            end else if (timer_q == LAST) begin
               state_d = S_EVAL;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_PAUSED: begin
            if (!bus.pause) state_d = S_RUN;
         end
         S_EVAL: begin
            state_d = S_COMMIT;
         end
         S_COMMIT: begin
            if (crashf_q)   state_d = S_CRASHED;
            else if (gnd_q) state_d = S_LANDED;
            else            state_d = S_RUN;
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   assign to_terminal = (state_d == S_LANDED) || (state_d == S_CRASHED);

   // Thrust register and the one-entry key hold used while the datapath
   // is mid-step (EVAL/COMMIT) so thrust never changes under a commit.
   always_comb begin
      thr_d      = thr_q;
      hold_d     = hold_q;
      hold_vld_d = hold_vld_q;
      unique case (state_q)
         S_IDLE, S_PAUSED: begin
            if (key_ok) thr_d = bus.key_digit;
         end
         S_RUN: begin
            // A live key is newer than a held one, so it wins.
            if (key_ok)          thr_d = bus.key_digit;
            else if (hold_vld_q) thr_d = hold_q;
            hold_vld_d = 1'b0;
         end
         S_EVAL: begin
            if (key_ok) begin
               hold_d     = bus.key_digit;
               hold_vld_d = 1'b1;
            end
         end
         S_COMMIT: begin
            // An empty tank kills thrust and drops any key arriving now.
            if (fuel_empty) begin
               thr_d = 4'd0;
            end else if (key_ok) begin
               hold_d     = bus.key_digit;
               hold_vld_d = 1'b1;
            end
            if (to_terminal) hold_vld_d = 1'b0;
         end
         default: begin
            thr_d = thr_q;
         end
      endcase
   end

   // State, timer and registered outputs of the step FSM.
   always_ff @(posedge hz100 or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         wen_q      <= 1'b0;
         busy_q     <= 1'b0;
         land_q     <= 1'b0;
         crash_q    <= 1'b0;
         step_cnt_q <= 8'd0;
         gnd_q      <= 1'b0;
         crashf_q   <= 1'b0;
         thr_q      <= THRUST[3:0];
         hold_q     <= 4'd0;
         hold_vld_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         wen_q      <= (state_d == S_COMMIT);
         busy_q     <= (state_d == S_RUN)  || (state_d == S_PAUSED) ||
                       (state_d == S_EVAL) || (state_d == S_COMMIT);
         thr_q      <= thr_d;
         hold_q     <= hold_d;
         hold_vld_q <= hold_vld_d;
         if (state_q == S_EVAL) begin
            gnd_q    <= ground;
            crashf_q <= crash_now;
         end
         if (state_q == S_COMMIT) begin
            if (step_cnt_q != 8'hFF) step_cnt_q <= step_cnt_q + 8'd1;
            if (state_d == S_CRASHED) crash_q <= 1'b1;
            if (state_d == S_LANDED)  land_q  <= 1'b1;
         end
      end
   end

   assign bus.wen      = wen_q;
   assign bus.thrust   = {12'h000, thr_q};
   assign bus.land     = land_q;
   assign bus.crash    = crash_q;
   assign bus.busy     = busy_q;
   assign bus.step_cnt = step_cnt_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_ll_step_sequencer.sv
// Bench for the lunar-lander step sequencer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// step-position model of the sequencer.
module tb_ll_step_sequencer;

   localparam int TD = 4;
   localparam logic [15:0] CV = 16'h9970;

   logic hz100;
   logic reset_n;
   ll_step_sequencer_if bus();

   ll_step_sequencer #(.TICK_DIV(TD), .CRASH_VEL(CV), .THRUST(16'h0005)) dut (
      .hz100  (hz100),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial hz100 = 1'b0;
   always #5 hz100 = ~hz100;

   int checks = 0;
   int errors = 0;

   // Model: started/terminal flags plus a position within the step
   // (0..TD-1 running, TD evaluating, TD+1 committing).
   int m_started, m_term, m_pos, m_paused;
   int m_gnd, m_cr, m_land, m_crash, m_cnt, m_thr, m_hold, m_holdv;

   function automatic int m_state();
      if (m_started == 0) return 0;
      if (m_term != 0)    return m_term;
      if (m_paused != 0)  return 4;
      if (m_pos < TD)     return 1;
      if (m_pos == TD)    return 2;
      return 3;
   endfunction

   task automatic model_reset();
      m_started = 0; m_term = 0; m_pos = 0; m_paused = 0;
      m_gnd = 0; m_cr = 0; m_land = 0; m_crash = 0; m_cnt = 0;
      m_thr = 5; m_hold = 0; m_holdv = 0;
   endtask

   task automatic model_step();
      int s;
      bit kok;
      s = m_state();
      if (reset_n == 1'b0) begin
         model_reset();
         return;
      end
      kok = bus.key_valid && (bus.key_digit <= 9);
      case (s)
         0: begin
            if (kok) m_thr = bus.key_digit;
            if (bus.start) begin m_started = 1; m_pos = 0; end
         end
         1: begin
            if (kok) m_thr = bus.key_digit;
            else if (m_holdv != 0) m_thr = m_hold;
            m_holdv = 0;
            if (bus.pause) m_paused = 1;
            else m_pos++;
         end
         4: begin
            if (kok) m_thr = bus.key_digit;
            if (!bus.pause) m_paused = 0;
         end
         2: begin
            m_gnd = (bus.alt_c >= 16'h8000 || bus.alt_c == 16'h0000) ? 1 : 0;
            m_cr  = (m_gnd != 0 && bus.vel < CV) ? 1 : 0;
            if (kok) begin m_hold = bus.key_digit; m_holdv = 1; end
            m_pos++;
         end
         3: begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            if (bus.fuel == 16'h0000) m_thr = 0;
            else if (kok) begin m_hold = bus.key_digit; m_holdv = 1; end
            if (m_cr != 0)       begin m_term = 6; m_crash = 1; m_holdv = 0; end
            else if (m_gnd != 0) begin m_term = 5; m_land = 1;  m_holdv = 0; end
            else m_pos = 0;
         end
         default: ;
      endcase
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare();
      int s;
      s = m_state();
      chk("state",    32'(bus.state),    32'(s));
      chk("wen",      32'(bus.wen),      (s == 3) ? 32'd1 : 32'd0);
      chk("busy",     32'(bus.busy),     (s >= 1 && s <= 4) ? 32'd1 : 32'd0);
      chk("thrust",   32'(bus.thrust),   32'(m_thr));
      chk("land",     32'(bus.land),     32'(m_land));
      chk("crash",    32'(bus.crash),    32'(m_crash));
      chk("step_cnt", 32'(bus.step_cnt), 32'(m_cnt));
   endtask

   // One clock: model absorbs the inputs applied for the coming edge, then
   // outputs are compared at the following falling edge.
   task automatic tick();
      model_step();
      @(negedge hz100);
      compare();
   endtask

   task automatic wait_model_state(input int s);
      int n;
      n = 0;
      while (m_state() != s && n < 60) begin
         tick();
         n++;
      end
      checks++;
      if (m_state() != s) begin
         errors++;
         $display("FAIL wait_state actual=%0d expected=%0d", m_state(), s);
      end
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
   endtask

   task automatic idle_inputs();
      bus.start = 0; bus.pause = 0; bus.key_valid = 0; bus.key_digit = 0;
      bus.fuel = 16'h0999; bus.vel = 16'h9990; bus.alt_c = 16'h0500;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      idle_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      chk("rst_state", 32'(bus.state), 32'd0);
      chk("rst_thrust", 32'(bus.thrust), 32'h0005);
      chk("rst_step", 32'(bus.step_cnt), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      tick();

      // Step cadence: wen on the 6th cycle after RUN entry, then every 6.
      bus.start = 1; tick(); bus.start = 0;
      chk("run_entry", 32'(bus.state), 32'd1);
      repeat (3) tick();
      tick();
      chk("eval_c5", 32'(bus.state), 32'd2);
      tick();
      chk("wen_c6", 32'(bus.wen), 32'd1);
      chk("cnt_in_commit", 32'(bus.step_cnt), 32'd0);
      tick();
      chk("cnt_1", 32'(bus.step_cnt), 32'd1);
      chk("wen_off", 32'(bus.wen), 32'd0);
      repeat (5) tick();
      chk("wen_c12", 32'(bus.wen), 32'd1);
      tick();
      chk("cnt_2", 32'(bus.step_cnt), 32'd2);

      // Pause at timer=2 for 10 cycles, then 3 cycles to EVAL, then COMMIT.
      tick(); tick();
      bus.pause = 1;
      repeat (10) tick();
      chk("paused", 32'(bus.state), 32'd4);
      bus.pause = 0;
      repeat (3) tick();
      chk("resume_eval", 32'(bus.state), 32'd2);
      tick();
      chk("resume_wen", 32'(bus.wen), 32'd1);
      tick();
      chk("cnt_3", 32'(bus.step_cnt), 32'd3);

      // Out-of-range key ignored.
      bus.key_valid = 1; bus.key_digit = 4'd12; tick();
      bus.key_valid = 0; tick();
      chk("key12", 32'(bus.thrust), 32'h0005);

      // Key during EVAL is deferred until back in RUN.
      wait_model_state(2);
      bus.key_valid = 1; bus.key_digit = 4'd7; tick();
      bus.key_valid = 0;
      chk("key7_commit", 32'(bus.thrust), 32'h0005);
      tick();
      chk("key7_run1", 32'(bus.thrust), 32'h0005);
      tick();
      chk("key7_run2", 32'(bus.thrust), 32'h0007);

      // Fuel empty at COMMIT beats a same-cycle key.
      wait_model_state(3);
      bus.fuel = 16'h0000; bus.key_valid = 1; bus.key_digit = 4'd3; tick();
      bus.fuel = 16'h0999; bus.key_valid = 0;
      chk("fuel0", 32'(bus.thrust), 32'h0000);
      tick(); tick();
      chk("fuel0_after", 32'(bus.thrust), 32'h0000);

      // Asynchronous reset while in EVAL.
      wait_model_state(2);
      reset_n = 1'b0;
      #1;
      chk("arst_state", 32'(bus.state), 32'd0);
      chk("arst_wen", 32'(bus.wen), 32'd0);
      chk("arst_thrust", 32'(bus.thrust), 32'h0005);
      chk("arst_step", 32'(bus.step_cnt), 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // Step counter saturation.
      bus.start = 1; tick(); bus.start = 0;
      repeat (260 * (TD + 2)) tick();
      chk("cnt_sat", 32'(bus.step_cnt), 32'd255);
      do_reset();

      // Crash: one commit, then terminal with no further writes.
      bus.alt_c = 16'h9990; bus.vel = 16'h9960;
      bus.start = 1; tick(); bus.start = 0;
      wait_model_state(3);
      chk("crash_wen", 32'(bus.wen), 32'd1);
      tick();
      chk("crash_state", 32'(bus.state), 32'd6);
      chk("crash_flag", 32'(bus.crash), 32'd1);
      chk("crash_land", 32'(bus.land), 32'd0);
      for (int i = 0; i < 20; i++) begin
         bus.start = 1'($urandom);
         bus.pause = 1'($urandom);
         bus.key_valid = 1'($urandom);
         bus.key_digit = 4'($urandom);
         tick();
      end
      chk("crash_cnt", 32'(bus.step_cnt), 32'd1);
      idle_inputs();
      do_reset();

      // Landing boundary: vel equal to threshold lands, one below crashes.
      bus.alt_c = 16'h0000; bus.vel = 16'h9970;
      bus.start = 1; tick(); bus.start = 0;
      repeat (TD + 2) tick();
      chk("land_state", 32'(bus.state), 32'd5);
      chk("land_flag", 32'(bus.land), 32'd1);
      chk("land_crash", 32'(bus.crash), 32'd0);
      do_reset();
      bus.alt_c = 16'h0000; bus.vel = 16'h9969;
      bus.start = 1; tick(); bus.start = 0;
      repeat (TD + 2) tick();
      chk("bnd_crash", 32'(bus.state), 32'd6);
      idle_inputs();
      do_reset();

      // Randomized traffic.
      for (int i = 0; i < 3000; i++) begin
         int pick;
         reset_n       = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
         bus.start     = ($urandom_range(0, 3) == 0);
         bus.pause     = ($urandom_range(0, 7) == 0);
         bus.key_valid = ($urandom_range(0, 3) == 0);
         bus.key_digit = 4'($urandom_range(0, 15));
         bus.fuel      = ($urandom_range(0, 11) == 0) ? 16'h0000 : 16'h0500;
         pick = $urandom_range(0, 59);
         bus.alt_c     = (pick == 0) ? 16'h0000 : (pick == 1) ? 16'h9990 :
                         (pick == 2) ? 16'h9999 : 16'h0300;
         case ($urandom_range(0, 5))
            0: bus.vel = 16'h9960;
            1: bus.vel = 16'h9969;
            2: bus.vel = 16'h9970;
            3: bus.vel = 16'h9971;
            4: bus.vel = 16'h9990;
            default: bus.vel = 16'h0010;
         endcase
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
